// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage types and constants for the rv32i core.
// Memory geometry and the entry bundle buffered toward decode.
package instr_fetch_unit_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] INSTR_MEM_SIZE = 32'h0000_0080;
  localparam logic [ADDR_WIDTH-1:0] INSTR_BYTES = 32'd4;
  localparam logic [ADDR_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
    logic fault;
  } fetch_entry_t;

  function automatic logic bad_fetch(
    input logic [ADDR_WIDTH-1:0] addr
  );
    return (addr[1:0] != 2'b00) ||
           (addr > INSTR_MEM_SIZE - INSTR_BYTES);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode valid/ready channel.
// The fetch side is master, decode is slave.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic if_valid;
  logic id_ready;
  logic [DATA_WIDTH-1:0] if_instr;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic if_fault;

  modport master (
    output if_valid,
    output if_instr,
    output if_pc,
    output if_fault,
    input  id_ready
  );

  modport slave (
    input  if_valid,
    input  if_instr,
    input  if_pc,
    input  if_fault,
    output id_ready
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Small sync FIFO of fetch entries with flush.
// Extra count bit separates full from empty.
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rv32i fetch stage: PC, fault detection, redirect
// handling and a fetch buffer feeding decode.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_instr,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  instr_fetch_unit_if.master    dec
);

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  halted;
  logic                  halted_next;
  logic                  fault_now;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  fetch_entry_t          entry;
  fetch_entry_t          head;

  assign imem_addr = pc;
  assign fault_now = bad_fetch(pc);

  // Redirect wins: the head shown this cycle is dropped, not consumed.
  assign pop  = !empty && dec.id_ready && !redirect_valid;
  assign push = !redirect_valid && !halted && (!full || pop);

  assign entry.pc    = pc;
  assign entry.instr = fault_now ? '0 : imem_instr;
  assign entry.fault = fault_now;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (entry),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign dec.if_valid = !empty;
  assign dec.if_instr = head.instr;
  assign dec.if_pc    = head.pc;
  assign dec.if_fault = head.fault;

  always_comb begin
    pc_next     = pc;
    halted_next = halted;
    unique case (1'b1)
      redirect_valid: begin
        pc_next     = redirect_pc;
        halted_next = 1'b0;
      end
      push && fault_now:  halted_next = 1'b1;
      push && !fault_now: pc_next = pc + INSTR_BYTES;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else begin
      pc     <= pc_next;
      halted <= halted_next;
    end
  end

endmodule
